// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared definitions for the memory-access pipeline stage:
//               FSM state encoding, default datapath widths and the
//               hard-wired zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    localparam int WIDTH_DEFAULT   = 32;
    localparam int REGBITS_DEFAULT = 5;

    // Register index that can never be written.
    localparam int REG_ZERO = 0;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/pipeline_mem_fsm.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_mem_fsm
// Description : Control FSM for the memory-access stage. Tracks whether a
//               data-memory access is outstanding, produces the upstream
//               ready, the memory request and a one-cycle completion strobe.
// Ports       : clk          - clock, rising edge
//               reset        - asynchronous, active-high reset
//               start_access - an accepted, issuable memory instruction
//               memack       - memory completes the access this cycle
//               ex_ready     - stage idle and able to accept
//               memreq       - access outstanding
//               ack_done     - access completes on this edge
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_mem_fsm
    import mips_mem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start_access,
    input  logic memack,
    output logic ex_ready,
    output logic memreq,
    output logic ack_done
);

    state_t state_q;
    state_t state_d;

    // Asynchronous reset makes memreq drop as soon as reset asserts, which
    // abandons any in-flight access without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_access) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (memack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ex_ready = (state_q == ST_IDLE);
    assign memreq   = (state_q == ST_ACCESS);
    // memack is only meaningful while a request is outstanding.
    assign ack_done = memreq && memack;

endmodule : pipeline_mem_fsm
`default_nettype wire

// File: rtl/pipeline_mem.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_mem
// Description : Memory-access pipeline stage. Holds the EX/MEM register,
//               runs the data-memory request/acknowledge handshake, stalls
//               upstream while an access is outstanding and produces
//               registered MEM/WB results (one wb_valid pulse per retired
//               instruction).
// Config      : MEM_ALIGN_CHECK_EN - when defined, memory instructions with a
//               non word-aligned address are not issued; they retire at once
//               with exc_misalign. When undefined, exc_misalign is tied 0.
// Ports       : clk, reset (async, active-high)
//               ex_*      - execution-stage instruction and handshake
//               mem*      - data-memory request/ack interface
//               wb_*      - registered write-back results
//               exc_misalign - misaligned-access pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_mem
    import mips_mem_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int REGBITS = REGBITS_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic               ex_memread,
    input  logic               ex_memwrite,
    input  logic               ex_regwrite,
    input  logic [WIDTH-1:0]   ex_aluout,
    input  logic [WIDTH-1:0]   ex_writedata,
    input  logic [REGBITS-1:0] ex_writereg,
    output logic               memreq,
    output logic               memwe,
    output logic [WIDTH-1:0]   memaddr,
    output logic [WIDTH-1:0]   memwdata,
    input  logic               memack,
    input  logic [WIDTH-1:0]   memrdata,
    output logic               wb_valid,
    output logic               wb_regwrite,
    output logic [REGBITS-1:0] wb_writereg,
    output logic [WIDTH-1:0]   wb_result,
    output logic               exc_misalign
);

    logic w_accept;
    logic w_is_mem;
    logic w_misalign;
    logic w_regwrite;
    logic w_ack_done;

    // EX/MEM register
    logic [WIDTH-1:0]   memaddr_q,  memaddr_d;
    logic [WIDTH-1:0]   memwdata_q, memwdata_d;
    logic               memwe_q,    memwe_d;
    logic               is_load_q,  is_load_d;
    logic               regwrite_q, regwrite_d;
    logic [REGBITS-1:0] writereg_q, writereg_d;

    // MEM/WB register
    logic               wb_valid_q,    wb_valid_d;
    logic               wb_regwrite_q, wb_regwrite_d;
    logic [REGBITS-1:0] wb_writereg_q, wb_writereg_d;
    logic [WIDTH-1:0]   wb_result_q,   wb_result_d;

    assign w_accept = ex_valid && ex_ready;
    assign w_is_mem = ex_memread || ex_memwrite;

`ifdef MEM_ALIGN_CHECK_EN
    logic exc_misalign_q;

    assign w_misalign = w_is_mem && (ex_aluout[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_misalign_q <= 1'b0;
        end else begin
            exc_misalign_q <= w_accept && w_misalign;
        end
    end

    assign exc_misalign = exc_misalign_q;
`else
    assign w_misalign   = 1'b0;
    assign exc_misalign = 1'b0;
`endif

    // Stores (including the illegal load+store combination, which is treated
    // as a store) never write a register, nor does the zero register.
    assign w_regwrite = ex_regwrite && !ex_memwrite &&
                        (ex_writereg != REGBITS'(REG_ZERO));

    pipeline_mem_fsm u_fsm (
        .clk          (clk),
        .reset        (reset),
        .start_access (w_accept && w_is_mem && !w_misalign),
        .memack       (memack),
        .ex_ready     (ex_ready),
        .memreq       (memreq),
        .ack_done     (w_ack_done)
    );

    always_comb begin
        memaddr_d     = memaddr_q;
        memwdata_d    = memwdata_q;
        memwe_d       = memwe_q;
        is_load_d     = is_load_q;
        regwrite_d    = regwrite_q;
        writereg_d    = writereg_q;
        wb_valid_d    = 1'b0;
        wb_regwrite_d = wb_regwrite_q;
        wb_writereg_d = wb_writereg_q;
        wb_result_d   = wb_result_q;

        // accept and ack_done are exclusive: one needs IDLE, the other ACCESS.
        if (w_accept) begin
            memaddr_d  = ex_aluout;
            memwdata_d = ex_writedata;
            memwe_d    = ex_memwrite;
            is_load_d  = ex_memread && !ex_memwrite;
            regwrite_d = w_regwrite;
            writereg_d = ex_writereg;
            // Non-memory and rejected (misaligned) instructions retire
            // directly from the accept edge.
            if (!w_is_mem || w_misalign) begin
                wb_valid_d    = 1'b1;
                wb_regwrite_d = w_regwrite && !w_misalign;
                wb_writereg_d = ex_writereg;
                wb_result_d   = ex_aluout;
            end
        end else if (w_ack_done) begin
            wb_valid_d    = 1'b1;
            wb_regwrite_d = regwrite_q;
            wb_writereg_d = writereg_q;
            wb_result_d   = is_load_q ? memrdata : memaddr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memaddr_q     <= '0;
            memwdata_q    <= '0;
            memwe_q       <= 1'b0;
            is_load_q     <= 1'b0;
            regwrite_q    <= 1'b0;
            writereg_q    <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_writereg_q <= '0;
            wb_result_q   <= '0;
        end else begin
            memaddr_q     <= memaddr_d;
            memwdata_q    <= memwdata_d;
            memwe_q       <= memwe_d;
            is_load_q     <= is_load_d;
            regwrite_q    <= regwrite_d;
            writereg_q    <= writereg_d;
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_writereg_q <= wb_writereg_d;
            wb_result_q   <= wb_result_d;
        end
    end

    assign memaddr     = memaddr_q;
    assign memwdata    = memwdata_q;
    assign memwe       = memwe_q && memreq;
    assign wb_valid    = wb_valid_q;
    assign wb_regwrite = wb_regwrite_q;
    assign wb_writereg = wb_writereg_q;
    assign wb_result   = wb_result_q;

endmodule : pipeline_mem
`default_nettype wire

// File: tb/tb_pipeline_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_mem
// Description : Directed self-checking bench for pipeline_mem. Expected
//               write-back records are queued when an instruction is issued
//               and matched against each wb_valid pulse.
// Config      : MEM_ALIGN_CHECK_EN selects the misaligned-access scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_mem;

    localparam int W  = 32;
    localparam int RB = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          ex_valid;
    logic          ex_ready;
    logic          ex_memread;
    logic          ex_memwrite;
    logic          ex_regwrite;
    logic [W-1:0]  ex_aluout;
    logic [W-1:0]  ex_writedata;
    logic [RB-1:0] ex_writereg;
    logic          memreq;
    logic          memwe;
    logic [W-1:0]  memaddr;
    logic [W-1:0]  memwdata;
    logic          memack;
    logic [W-1:0]  memrdata;
    logic          wb_valid;
    logic          wb_regwrite;
    logic [RB-1:0] wb_writereg;
    logic [W-1:0]  wb_result;
    logic          exc_misalign;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [RB-1:0] rd;
        logic          rw;
        logic [W-1:0]  res;
        bit            chk_res;
    } wb_t;

    wb_t sb[$];

    always #5 clk = ~clk;

    pipeline_mem #(.WIDTH(W), .REGBITS(RB)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_memread   (ex_memread),
        .ex_memwrite  (ex_memwrite),
        .ex_regwrite  (ex_regwrite),
        .ex_aluout    (ex_aluout),
        .ex_writedata (ex_writedata),
        .ex_writereg  (ex_writereg),
        .memreq       (memreq),
        .memwe        (memwe),
        .memaddr      (memaddr),
        .memwdata     (memwdata),
        .memack       (memack),
        .memrdata     (memrdata),
        .wb_valid     (wb_valid),
        .wb_regwrite  (wb_regwrite),
        .wb_writereg  (wb_writereg),
        .wb_result    (wb_result),
        .exc_misalign (exc_misalign)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [RB-1:0] rd, input logic rw, input logic [W-1:0] res, input bit chk);
        wb_t e;
        e.rd      = rd;
        e.rw      = rw;
        e.res     = res;
        e.chk_res = chk;
        sb.push_back(e);
    endtask

    // Advance one clock, sample just after the edge and match any write-back.
    task automatic step();
        wb_t e;
        @(posedge clk);
        #1;
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", W'(wb_valid), W'(0));
            end else begin
                e = sb.pop_front();
                check("wb_writereg", W'(wb_writereg), W'(e.rd));
                check("wb_regwrite", W'(wb_regwrite), W'(e.rw));
                if (e.chk_res) begin
                    check("wb_result", wb_result, e.res);
                end
            end
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic rw,
                         input logic [W-1:0] alu, input logic [W-1:0] wd,
                         input logic [RB-1:0] wreg);
        ex_valid     = 1'b1;
        ex_memread   = rd;
        ex_memwrite  = wr;
        ex_regwrite  = rw;
        ex_aluout    = alu;
        ex_writedata = wd;
        ex_writereg  = wreg;
    endtask

    task automatic idle();
        ex_valid     = 1'b0;
        ex_memread   = 1'b0;
        ex_memwrite  = 1'b0;
        ex_regwrite  = 1'b0;
        ex_aluout    = '0;
        ex_writedata = '0;
        ex_writereg  = '0;
    endtask

    initial begin
        reset    = 1'b1;
        memack   = 1'b0;
        memrdata = '0;
        idle();

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_memreq",   W'(memreq),       W'(0));
        check("rst_memwe",    W'(memwe),        W'(0));
        check("rst_memaddr",  memaddr,          W'(0));
        check("rst_memwdata", memwdata,         W'(0));
        check("rst_wb_valid", W'(wb_valid),     W'(0));
        check("rst_wb_rw",    W'(wb_regwrite),  W'(0));
        check("rst_wb_reg",   W'(wb_writereg),  W'(0));
        check("rst_wb_res",   wb_result,        W'(0));
        check("rst_exc",      W'(exc_misalign), W'(0));
        reset = 1'b0;
        check("rst_ready",    W'(ex_ready),     W'(1));

        // ---- ALU op; memack while idle must be ignored ----
        issue(1'b0, 1'b0, 1'b1, 32'h0000_0010, '0, 5'd8);
        memack = 1'b1;
        push(5'd8, 1'b1, 32'h0000_0010, 1'b1);
        step();
        check("alu_wbv",    W'(wb_valid), W'(1));
        check("alu_memreq", W'(memreq),   W'(0));
        memack = 1'b0;
        idle();
        step();
        check("alu_pulse",  W'(wb_valid), W'(0));

        // ---- load, ack in the third ACCESS cycle ----
        issue(1'b1, 1'b0, 1'b1, 32'h0000_0100, '0, 5'd9);
        push(5'd9, 1'b1, 32'hDEAD_BEEF, 1'b1);
        check("ld_ready_pre", W'(ex_ready), W'(1));
        step();
        idle();
        memrdata = 32'h0BAD_F00D;
        for (int i = 0; i < 3; i++) begin
            check("ld_memreq",  W'(memreq),   W'(1));
            check("ld_memaddr", memaddr,      32'h0000_0100);
            check("ld_memwe",   W'(memwe),    W'(0));
            check("ld_ready",   W'(ex_ready), W'(0));
            check("ld_wbv",     W'(wb_valid), W'(0));
            if (i == 2) begin
                memack   = 1'b1;
                memrdata = 32'hDEAD_BEEF;
            end
            step();
        end
        memack   = 1'b0;
        memrdata = '0;
        check("ld_done_wbv",   W'(wb_valid), W'(1));
        check("ld_done_req",   W'(memreq),   W'(0));
        check("ld_done_ready", W'(ex_ready), W'(1));

        // ---- store, zero-wait ----
        issue(1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 5'd10);
        memack = 1'b1;
        push(5'd10, 1'b0, 32'h0000_0200, 1'b1);
        step();
        idle();
        check("st_memreq", W'(memreq),   W'(1));
        check("st_memwe",  W'(memwe),    W'(1));
        check("st_wdata",  memwdata,     32'h1234_5678);
        check("st_addr",   memaddr,      32'h0000_0200);
        check("st_wbv0",   W'(wb_valid), W'(0));
        step();
        memack = 1'b0;
        check("st_wbv",    W'(wb_valid), W'(1));
        check("st_req_lo", W'(memreq),   W'(0));
        check("st_we_lo",  W'(memwe),    W'(0));

        // ---- back-to-back ALU ops, first targets the zero register ----
        issue(1'b0, 1'b0, 1'b1, 32'h0000_CAFE, '0, 5'd0);
        push(5'd0, 1'b0, 32'h0000_CAFE, 1'b1);
        step();
        check("r0_wbv",   W'(wb_valid), W'(1));
        check("r0_ready", W'(ex_ready), W'(1));
        issue(1'b0, 1'b0, 1'b0, 32'h0000_0033, '0, 5'd3);
        push(5'd3, 1'b0, 32'h0000_0033, 1'b1);
        step();
        check("b2b_wbv",  W'(wb_valid), W'(1));
        idle();
        step();
        check("hold_wbv", W'(wb_valid),    W'(0));
        check("hold_res", wb_result,       32'h0000_0033);
        check("hold_reg", W'(wb_writereg), W'(3));

        // ---- illegal load+store treated as store ----
        issue(1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_00AA, 5'd5);
        memack = 1'b1;
        push(5'd5, 1'b0, 32'h0000_0300, 1'b1);
        step();
        idle();
        check("ill_memwe", W'(memwe), W'(1));
        step();
        memack = 1'b0;
        check("ill_wbv",   W'(wb_valid), W'(1));

        // ---- reset during ACCESS discards the load ----
        issue(1'b1, 1'b0, 1'b1, 32'h0000_0400, '0, 5'd7);
        step();
        idle();
        check("rsta_memreq", W'(memreq), W'(1));
        #2;
        reset = 1'b1;
        #1;
        check("rsta_req_async", W'(memreq),   W'(0));
        check("rsta_ready",     W'(ex_ready), W'(1));
        memack = 1'b1;
        memrdata = 32'h5555_5555;
        step();
        check("rsta_wbv_in", W'(wb_valid), W'(0));
        memack = 1'b0;
        reset  = 1'b0;
        step();
        check("rsta_wbv_out", W'(wb_valid), W'(0));
        check("rsta_req_out", W'(memreq),   W'(0));
        issue(1'b0, 1'b0, 1'b1, 32'h0000_0055, '0, 5'd12);
        push(5'd12, 1'b1, 32'h0000_0055, 1'b1);
        step();
        idle();
        check("post_rst_wbv", W'(wb_valid), W'(1));

`ifdef MEM_ALIGN_CHECK_EN
        // ---- misaligned load is rejected ----
        issue(1'b1, 1'b0, 1'b1, 32'h0000_0102, '0, 5'd4);
        push(5'd4, 1'b0, '0, 1'b0);
        step();
        idle();
        check("mis_memreq", W'(memreq),       W'(0));
        check("mis_exc",    W'(exc_misalign), W'(1));
        check("mis_wbv",    W'(wb_valid),     W'(1));
        check("mis_ready",  W'(ex_ready),     W'(1));
        step();
        check("mis_exc_lo", W'(exc_misalign), W'(0));
        check("mis_req_lo", W'(memreq),       W'(0));
`else
        // ---- unaligned address passes straight to memory ----
        issue(1'b1, 1'b0, 1'b1, 32'h0000_0102, '0, 5'd4);
        memack   = 1'b1;
        memrdata = 32'h0000_0077;
        push(5'd4, 1'b1, 32'h0000_0077, 1'b1);
        step();
        idle();
        check("ua_memreq", W'(memreq),       W'(1));
        check("ua_addr",   memaddr,          32'h0000_0102);
        check("ua_exc",    W'(exc_misalign), W'(0));
        step();
        memack = 1'b0;
        check("ua_wbv",    W'(wb_valid),     W'(1));
`endif

        step();
        check("sb_empty", W'(sb.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipeline_mem
`default_nettype wire
